// File: rtl/fb_writer_if.sv
// Pixel request channel and framebuffer RAM write port for fb_writer.
// slave is the writer's view; master is the view of the pixel source and RAM.
interface fb_writer_if #(
    parameter int ADDRW = 20,
    parameter int DATAW = 12,
    parameter int CORDW = 10
) ();
    logic             pix_valid;
    logic             pix_ready;
    logic [CORDW-1:0] pix_x;
    logic [CORDW-1:0] pix_y;
    logic [DATAW-1:0] pix_color;
    logic [ADDRW-1:0] ram_address;
    logic             ram_write_enable;
    logic [DATAW-1:0] ram_data;

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color,
        output pix_ready, ram_address, ram_write_enable, ram_data
    );

    modport master (
        output pix_valid, pix_x, pix_y, pix_color,
        input  pix_ready, ram_address, ram_write_enable, ram_data
    );
endinterface

// File: rtl/fb_writer.sv
// Framebuffer write engine: pixel writes, whole-buffer clear fills and
// double-buffer swaps that are deferred to frame boundaries.
//
// state | meaning
// IDLE  | accepting pixels, clear and swap requests
// CLEAR | filling the back buffer with the latched colour, one word per cycle
module fb_writer #(
    parameter int ADDRW      = 20,
    parameter int DATAW      = 12,
    parameter int CORDW      = 10,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FRAME_SIZE = 307200
) (
    input  logic             clk,
    input  logic             rst,
    fb_writer_if.slave       bus,
    input  logic             clear_start_i,
    input  logic [DATAW-1:0] clear_color_i,
    input  logic             swap_req_i,
    input  logic             frame_start_i,
    output logic [ADDRW-1:0] front_offset_o,
    output logic             busy_o,
    output logic             swap_pending_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDRW-1:0] FS_W  = ADDRW'(FRAME_SIZE);
    localparam logic [ADDRW-1:0] HRES_W = ADDRW'(H_RES);
    localparam logic [CORDW-1:0] X_LIM = CORDW'(H_RES);
    localparam logic [CORDW-1:0] Y_LIM = CORDW'(V_RES);

    state_t           state_q, state_d;
    logic             buf_sel_q, buf_sel_d;
    logic [ADDRW-1:0] front_offset_q, front_offset_d;
    logic             swap_pending_q, swap_pending_d;
    logic [ADDRW-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDRW-1:0] ram_addr_q, ram_addr_d;
    logic [DATAW-1:0] ram_data_q, ram_data_d;
    logic             ram_we_q, ram_we_d;

    logic [ADDRW-1:0] back_base;
    logic [ADDRW-1:0] pix_offset;
    logic             pix_in_range;
    logic             pix_ready;
    logic             pix_accept;
    logic             clear_go;
    logic             do_swap;

    assign back_base    = buf_sel_q ? '0 : FS_W;
    assign pix_offset   = ADDRW'(bus.pix_y) * HRES_W + ADDRW'(bus.pix_x);
    assign pix_in_range = (bus.pix_x < X_LIM) && (bus.pix_y < Y_LIM);

    // A same-cycle clear_start always wins over a pixel, even if the clear is ignored.
    assign pix_ready  = (state_q == IDLE) && !swap_pending_q && !clear_start_i;
    assign pix_accept = bus.pix_valid && pix_ready;
    assign clear_go   = clear_start_i && (state_q == IDLE) && !swap_pending_q;
    assign do_swap    = frame_start_i && swap_pending_q && (state_q == IDLE);

    always_comb begin
        state_d        = state_q;
        buf_sel_d      = buf_sel_q;
        swap_pending_d = swap_pending_q | swap_req_i;
        clr_cnt_d      = clr_cnt_q;
        ram_addr_d     = ram_addr_q;
        ram_data_d     = ram_data_q;
        ram_we_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_go) begin
                    state_d    = CLEAR;
                    ram_we_d   = 1'b1;
                    ram_addr_d = back_base;
                    ram_data_d = clear_color_i;
                    clr_cnt_d  = ADDRW'(1);
                end else if (pix_accept && pix_in_range) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = back_base + pix_offset;
                    ram_data_d = bus.pix_color;
                end
                if (do_swap) begin
                    buf_sel_d      = ~buf_sel_q;
                    swap_pending_d = 1'b0;
                end
            end
            CLEAR: begin
                // ram_data_q still carries the clear colour from the first write.
                if (clr_cnt_q == FS_W) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = back_base + clr_cnt_q;
                    clr_cnt_d  = clr_cnt_q + ADDRW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                clr_cnt_d = '0;
            end
        endcase

        front_offset_d = buf_sel_d ? FS_W : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            buf_sel_q      <= 1'b0;
            front_offset_q <= '0;
            swap_pending_q <= 1'b0;
            clr_cnt_q      <= '0;
            ram_addr_q     <= '0;
            ram_data_q     <= '0;
            ram_we_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_sel_q      <= buf_sel_d;
            front_offset_q <= front_offset_d;
            swap_pending_q <= swap_pending_d;
            clr_cnt_q      <= clr_cnt_d;
            ram_addr_q     <= ram_addr_d;
            ram_data_q     <= ram_data_d;
            ram_we_q       <= ram_we_d;
        end
    end

    assign bus.pix_ready        = pix_ready;
    assign bus.ram_address      = ram_addr_q;
    assign bus.ram_data         = ram_data_q;
    assign bus.ram_write_enable = ram_we_q;
    assign front_offset_o       = front_offset_q;
    assign busy_o               = (state_q == CLEAR);
    assign swap_pending_o       = swap_pending_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer on a reduced 40x30 frame (FRAME_SIZE 1200)
// so that full clear fills stay short.
module tb_fb_writer;
    localparam int ADDRW = 20;
    localparam int DATAW = 12;
    localparam int CORDW = 10;
    localparam int H_RES = 40;
    localparam int V_RES = 30;
    localparam int FS    = 1200;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear_start = 1'b0;
    logic [DATAW-1:0] clear_color = '0;
    logic             swap_req = 1'b0;
    logic             frame_start = 1'b0;
    logic [ADDRW-1:0] front_offset;
    logic             busy;
    logic             swap_pending;

    int n_checks = 0;
    int n_errors = 0;

    fb_writer_if #(.ADDRW(ADDRW), .DATAW(DATAW), .CORDW(CORDW)) bus ();

    fb_writer #(
        .ADDRW(ADDRW), .DATAW(DATAW), .CORDW(CORDW),
        .H_RES(H_RES), .V_RES(V_RES), .FRAME_SIZE(FS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .clear_start_i  (clear_start),
        .clear_color_i  (clear_color),
        .swap_req_i     (swap_req),
        .frame_start_i  (frame_start),
        .front_offset_o (front_offset),
        .busy_o         (busy),
        .swap_pending_o (swap_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int x, input int y, input logic [DATAW-1:0] c);
        bus.pix_valid = 1'b1;
        bus.pix_x     = CORDW'(x);
        bus.pix_y     = CORDW'(y);
        bus.pix_color = c;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr, bad, cnt;
        bus.pix_valid = 1'b0;
        bus.pix_x     = '0;
        bus.pix_y     = '0;
        bus.pix_color = '0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        check("rst_front",   32'(front_offset), 0);
        check("rst_we",      32'(bus.ram_write_enable), 0);
        check("rst_addr",    32'(bus.ram_address), 0);
        check("rst_data",    32'(bus.ram_data), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_pending", 32'(swap_pending), 0);
        #1 check("rst_ready", 32'(bus.pix_ready), 1);

        // first pixel lands in the back buffer at FS + 2*40 + 3
        pixel(3, 2, 12'hABC);
        #1 check("px1_ready", 32'(bus.pix_ready), 1);
        tick();
        bus.pix_valid = 1'b0;
        check("px1_we",    32'(bus.ram_write_enable), 1);
        check("px1_addr",  32'(bus.ram_address), 1283);
        check("px1_data",  32'(bus.ram_data), 32'h0ABC);
        check("px1_front", 32'(front_offset), 0);
        tick();
        check("idle_we",   32'(bus.ram_write_enable), 0);
        check("idle_addr", 32'(bus.ram_address), 1283);

        // out-of-range pixels handshake but do not write
        pixel(40, 0, 12'h111);
        #1 check("oobx_ready", 32'(bus.pix_ready), 1);
        tick();
        check("oobx_we", 32'(bus.ram_write_enable), 0);
        pixel(0, 30, 12'h222);
        #1 check("ooby_ready", 32'(bus.pix_ready), 1);
        tick();
        check("ooby_we",   32'(bus.ram_write_enable), 0);
        check("oob_addr",  32'(bus.ram_address), 1283);
        pixel(39, 29, 12'h333);
        tick();
        pixel(1, 0, 12'h444);
        check("corner_we",   32'(bus.ram_write_enable), 1);
        check("corner_addr", 32'(bus.ram_address), 2399);
        check("corner_data", 32'(bus.ram_data), 32'h333);
        tick();
        pixel(5, 1, 12'h555);
        check("b2b1_addr", 32'(bus.ram_address), 1201);
        check("b2b1_data", 32'(bus.ram_data), 32'h444);
        tick();
        bus.pix_valid = 1'b0;
        check("b2b2_we",   32'(bus.ram_write_enable), 1);
        check("b2b2_addr", 32'(bus.ram_address), 1245);
        check("b2b2_data", 32'(bus.ram_data), 32'h555);
        tick();
        check("b2b_end_we", 32'(bus.ram_write_enable), 0);

        // clear with a same-cycle pixel; second clear_start mid-fill ignored
        clear_start = 1'b1;
        clear_color = 12'h0F0;
        pixel(0, 0, 12'hFFF);
        #1 check("clr_ready", 32'(bus.pix_ready), 0);
        tick();
        clear_start   = 1'b0;
        clear_color   = '0;
        bus.pix_valid = 1'b0;
        check("clr_busy", 32'(busy), 1);
        wr  = 0;
        bad = 0;
        for (int i = 0; i < FS + 100; i++) begin
            if (!busy) break;
            if (!bus.ram_write_enable || bus.ram_address != ADDRW'(FS + wr)
                || bus.ram_data != 12'h0F0) bad++;
            wr++;
            if (i == 10) check("clr_ready_busy", 32'(bus.pix_ready), 0);
            if (i == 500) begin
                clear_start = 1'b1;
                clear_color = 12'h00F;
            end else begin
                clear_start = 1'b0;
            end
            tick();
        end
        clear_start = 1'b0;
        check("clr_writes",   32'(wr), FS);
        check("clr_bad",      32'(bad), 0);
        check("clr_done",     32'(busy), 0);
        check("clr_end_we",   32'(bus.ram_write_enable), 0);
        check("clr_end_addr", 32'(bus.ram_address), 2399);

        // swap: pixels stall while pending, clear ignored while pending
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("swp_pending", 32'(swap_pending), 1);
        pixel(0, 0, 12'h123);
        #1 check("swp_ready", 32'(bus.pix_ready), 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            clear_start = (i == 3);
            tick();
            if (bus.ram_write_enable) cnt++;
        end
        clear_start = 1'b0;
        check("swp_stall_we", 32'(cnt), 0);
        check("swp_clr_ign",  32'(busy), 0);
        check("swp_front_pre", 32'(front_offset), 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("swp_front",   32'(front_offset), FS);
        check("swp_cleared", 32'(swap_pending), 0);
        #1 check("swp_ready_after", 32'(bus.pix_ready), 1);
        tick();
        bus.pix_valid = 1'b0;
        check("swp_px_we",   32'(bus.ram_write_enable), 1);
        check("swp_px_addr", 32'(bus.ram_address), 0);
        check("swp_px_data", 32'(bus.ram_data), 32'h123);

        // swap_req together with frame_start defers to the next frame_start
        swap_req    = 1'b1;
        frame_start = 1'b1;
        tick();
        swap_req    = 1'b0;
        frame_start = 1'b0;
        check("same_front",   32'(front_offset), FS);
        check("same_pending", 32'(swap_pending), 1);
        repeat (3) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("same_front2",   32'(front_offset), 0);
        check("same_pending2", 32'(swap_pending), 0);

        // swap requested during a clear waits for a frame_start after the fill
        clear_start = 1'b1;
        clear_color = 12'h321;
        tick();
        clear_start = 1'b0;
        check("clr2_busy", 32'(busy), 1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        repeat (50) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("clr2_noswap",  32'(front_offset), 0);
        check("clr2_pending", 32'(swap_pending), 1);
        cnt = 0;
        while (busy && cnt < FS + 100) begin
            tick();
            cnt++;
        end
        check("clr2_done",       32'(busy), 0);
        check("clr2_front_hold", 32'(front_offset), 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("clr2_swap",     32'(front_offset), FS);
        check("clr2_pend_clr", 32'(swap_pending), 0);

        // asynchronous reset in the middle of a fill
        clear_start = 1'b1;
        clear_color = 12'h777;
        tick();
        clear_start = 1'b0;
        repeat (40) tick();
        check("arst_pre_we", 32'(bus.ram_write_enable), 1);
        #3 rst = 1'b1;
        #1;
        check("arst_we",      32'(bus.ram_write_enable), 0);
        check("arst_front",   32'(front_offset), 0);
        check("arst_busy",    32'(busy), 0);
        check("arst_pending", 32'(swap_pending), 0);
        check("arst_addr",    32'(bus.ram_address), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            tick();
            if (bus.ram_write_enable) cnt++;
        end
        check("arst_no_writes", 32'(cnt), 0);
        check("arst_idle_busy", 32'(busy), 0);
        pixel(1, 1, 12'h0AA);
        tick();
        bus.pix_valid = 1'b0;
        check("arst_px_we",   32'(bus.ram_write_enable), 1);
        check("arst_px_addr", 32'(bus.ram_address), 1241);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Write-side companion to the VGA scan-out path: converts pixel write requests (x, y, colour) into framebuffer RAM write cycles.
- Owns the double-buffer select and performs whole-frame clear fills.
- Exports the front-buffer offset that the display path adds to its read address.
- Back-buffer swaps happen only at frame boundaries, so scan-out never shows a half-drawn frame.

Parameters:
ADDRW, 20, RAM address width (must hold 2*FRAME_SIZE)
DATAW, 12, pixel width ({B[11:8],G[7:4],R[3:0]})
CORDW, 10, coordinate width
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
FRAME_SIZE, 307200, words per buffer (H_RES*V_RES)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  reset, asynchronous, active-high
pix_valid  in  1  pixel write request
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
pix_x  in  CORDW  pixel column
pix_y  in  CORDW  pixel row
pix_color  in  DATAW  pixel colour
clear_start  in  1  one-cycle pulse: fill back buffer with clear_color
clear_color  in  DATAW  fill colour, sampled with clear_start
swap_req  in  1  one-cycle pulse: request front/back swap
frame_start  in  1  one-cycle pulse in clk domain at start of vertical blanking
front_offset  out  ADDRW  base address of the buffer being displayed
ram_address  out  ADDRW  write address
ram_write_enable  out  1  write strobe, one word per cycle
ram_data  out  DATAW  write data
busy  out  1  high while clearing
swap_pending  out  1  swap requested, not yet applied

Behaviour:
- Reset (async assert; release is synchronous to clk):
  - state=IDLE, buf_sel=0, front_offset=0.
  - ram_address=0, ram_data=0, ram_write_enable=0.
  - busy=0, swap_pending=0, clear counter=0.
  - Reset during CLEAR aborts the fill and produces no further writes.
- Buffer offsets:
  - buf_sel=0: front=0, back=FRAME_SIZE.
  - buf_sel=1: front=FRAME_SIZE, back=0.
  - front_offset is registered and changes only on a swap.
- FSM states: IDLE, CLEAR.
- pix_ready (combinational) = (state==IDLE) && !swap_pending && !clear_start.
  - clear_start has priority over a same-cycle pixel.
- Pixel path, IDLE:
  - On accept in cycle N, cycle N+1 has ram_write_enable=1, ram_address=back+pix_y*H_RES+pix_x, ram_data=pix_color.
  - Throughput is one pixel per cycle.
  - Address arithmetic is done at ADDRW width with no truncation for in-range inputs.
- Out-of-range pixels (pix_x>=H_RES or pix_y>=V_RES) are accepted (handshake completes) but dropped: ram_write_enable=0 in N+1.
- ram_write_enable is 0 in every cycle with no write. ram_address and ram_data hold their last value.
- Clear:
  - Accepted only when state==IDLE && !swap_pending; otherwise ignored.
  - Latches clear_color. Next cycle: state=CLEAR, busy=1.
  - Writes back+k for k=0..FRAME_SIZE-1, one per consecutive cycle, ram_write_enable=1 throughout.
  - After the write of k=FRAME_SIZE-1: state=IDLE, busy=0.
  - Total FRAME_SIZE write cycles; the first write lands one cycle after the clear_start cycle.
  - clear_start during CLEAR is ignored.
- Swap:
  - swap_req sets swap_pending (repeat requests are idempotent).
  - On a frame_start with swap_pending && state==IDLE: toggle buf_sel; front_offset updates and swap_pending clears on the same edge.
  - frame_start while in CLEAR does not swap; the swap waits for a later frame_start.
  - swap_req and frame_start in the same cycle: the swap does not occur that cycle. It waits for the next frame_start.
  - Pixels are stalled (pix_ready=0) while swap_pending, so no write can land in the buffer about to be displayed.
  - A write issued in the cycle after an accept still targets the pre-swap back buffer.

Test Plan:
- Reset, then accept pixel (x=3, y=2, colour 0xABC) -> one cycle later ram_write_enable=1, ram_address=FRAME_SIZE+1283, ram_data=0xABC; front_offset=0.
- Pixel x=640, y=0 and pixel x=0, y=480 -> both handshakes complete, no write strobe; a following valid pixel (639,479) writes address FRAME_SIZE+307199.
- clear_start with clear_color=0x0F0 (pixel valid same cycle) -> pix_ready=0 that cycle; 307200 consecutive writes FRAME_SIZE..614399 of 0x0F0; busy drops after the last one; a second clear_start mid-fill is ignored.
- swap_req, then frame_start 10 cycles later -> pix_ready=0 for those cycles; front_offset becomes 307200 on the frame_start edge; next pixel (0,0) writes address 0.
- swap_req during a clear, frame_start before the clear ends -> no swap; first frame_start after busy falls swaps.
- Assert rst mid-clear, asynchronously between edges -> ram_write_enable=0 and front_offset=0 immediately; busy=0; no writes after release until a new request.
